// File: rtl/sdram_vga_rd_ctrl.sv
// Display-side reader of the SDRAM read FIFO: raster timing, FIFO read requests
// ahead of active pixels, registered pixel output and per-frame read rewind.
//
// state     | meaning
// WAIT_INIT | SDRAM not ready; counters and outputs held at 0
// FLUSH     | rd_rst asserted for RST_LEN clocks before the first frame
// RUN       | raster counters running, sdram_read_valid high
module sdram_vga_rd_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int RST_LEN = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [15:0] rd_fifo_rd_data,
    output logic        rd_fifo_rd_req,
    output logic        rd_rst,
    output logic        sdram_read_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_de,
    output logic [15:0] pix_data,
    output logic [11:0] pix_x,
    output logic [15:0] frame_cnt
);

    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_E = 12'(V_SYNC);
    localparam logic [11:0] H_DE_BEG = 12'(HA);
    localparam logic [11:0] H_DE_END = 12'(HA + H_VALID);
    localparam logic [11:0] H_RQ_BEG = 12'(HA - 2);
    localparam logic [11:0] H_RQ_END = 12'(HA + H_VALID - 2);
    localparam logic [11:0] V_DE_BEG = 12'(VA);
    localparam logic [11:0] V_DE_END = 12'(VA + V_VALID);
    localparam logic [3:0]  RST_LAST = 4'(RST_LEN - 1);

    localparam logic [1:0] ST_WAIT_INIT = 2'd0;
    localparam logic [1:0] ST_FLUSH     = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic [1:0]  state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [3:0]  rst_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        in_v;
    logic        de_dec;
    logic        req_dec;
    logic        frame_end;

    // Requests lead the data-enable window by two clocks: one for the request
    // register, one for the FIFO read latency.
    always_comb begin
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        in_v      = (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
        de_dec    = in_v && (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
        req_dec   = in_v && (h_cnt >= H_RQ_BEG) && (h_cnt < H_RQ_END);
        frame_end = (h_cnt == 12'd0) && (v_cnt == V_DE_END);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= ST_WAIT_INIT;
            h_cnt            <= 12'd0;
            v_cnt            <= 12'd0;
            rst_cnt          <= 4'd0;
            rd_fifo_rd_req   <= 1'b0;
            rd_rst           <= 1'b0;
            sdram_read_valid <= 1'b0;
            hsync            <= 1'b0;
            vsync            <= 1'b0;
            pix_de           <= 1'b0;
            pix_data         <= 16'd0;
            pix_x            <= 12'd0;
            frame_cnt        <= 16'd0;
        end else if (!init_end) begin
            state            <= ST_WAIT_INIT;
            h_cnt            <= 12'd0;
            v_cnt            <= 12'd0;
            rst_cnt          <= 4'd0;
            rd_fifo_rd_req   <= 1'b0;
            rd_rst           <= 1'b0;
            sdram_read_valid <= 1'b0;
            hsync            <= 1'b0;
            vsync            <= 1'b0;
            pix_de           <= 1'b0;
            pix_data         <= 16'd0;
            pix_x            <= 12'd0;
            frame_cnt        <= 16'd0;
        end else begin
            case (state)
                ST_WAIT_INIT: begin
                    state   <= ST_FLUSH;
                    rd_rst  <= 1'b1;
                    rst_cnt <= RST_LAST;
                end
                ST_FLUSH: begin
                    if (rst_cnt == 4'd0) begin
                        state            <= ST_RUN;
                        rd_rst           <= 1'b0;
                        sdram_read_valid <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 4'd1;
                    end
                end
                ST_RUN: begin
                    h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
                    if (h_wrap) begin
                        v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
                    end
                    hsync          <= (h_cnt < H_SYNC_E);
                    vsync          <= (v_cnt < V_SYNC_E);
                    pix_de         <= de_dec;
                    rd_fifo_rd_req <= req_dec;
                    pix_data       <= de_dec ? rd_fifo_rd_data : 16'd0;
                    pix_x          <= de_dec ? (h_cnt - H_DE_BEG) : 12'd0;
                    // Rewind pulse sits in the front porch, clear of any request.
                    if (frame_end) begin
                        rd_rst    <= 1'b1;
                        rst_cnt   <= RST_LAST;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else if (rd_rst) begin
                        if (rst_cnt == 4'd0) begin
                            rd_rst <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt - 4'd1;
                        end
                    end
                end
                default: state <= ST_WAIT_INIT;
            endcase
        end
    end

endmodule
